// File: rtl/dac_stream_scheduler.sv
// dac_stream_scheduler: paces two buffered sample streams into a DAC driver at a
// programmable sample period, with underrun counting and a minimum ce spacing guard.
module dac_stream_scheduler #(
  parameter int DATA_WIDTH   = 14,
  parameter int PERIOD_WIDTH = 16,
  parameter int MIN_PERIOD   = 128
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    enable,
  input  logic [PERIOD_WIDTH-1:0] period,
  input  logic                    validA,
  input  logic [DATA_WIDTH-1:0]   dataInA,
  output logic                    readyA,
  input  logic                    validB,
  input  logic [DATA_WIDTH-1:0]   dataInB,
  output logic                    readyB,
  output logic                    ce,
  output logic [DATA_WIDTH-1:0]   dataA,
  output logic [DATA_WIDTH-1:0]   dataB,
  output logic [7:0]              underrunA,
  output logic [7:0]              underrunB,
  input  logic                    clrUnderrun
);
  localparam int GW = $clog2(MIN_PERIOD + 1);
  localparam logic [PERIOD_WIDTH-1:0] MINP = PERIOD_WIDTH'(MIN_PERIOD);
  localparam logic [GW-1:0] GUARD_LD = GW'(MIN_PERIOD - 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d, eff_q, eff_d;
  logic [GW-1:0] guard_q, guard_d;
  logic full_a_q, full_a_d, full_b_q, full_b_d, ce_q, ce_d;
  logic [DATA_WIDTH-1:0] buf_a_q, buf_a_d, buf_b_q, buf_b_d;
  logic [DATA_WIDTH-1:0] data_a_q, data_a_d, data_b_q, data_b_d;
  logic [7:0] und_a_q, und_a_d, und_b_q, und_b_d;
  logic run, live, wrap, tick, ld_a, ld_b;
  always_comb begin
    run      = state_q == RUN;
    live     = run && enable;
    readyA   = run && !full_a_q;
    readyB   = run && !full_b_q;
    ld_a     = validA && readyA;
    ld_b     = validB && readyB;
    // period is only looked at on count 0; the rest of the period uses the latched value
    eff_d    = cnt_q == '0 ? (period < MINP ? MINP : period) : eff_q;
    wrap     = live && cnt_q == eff_d - 1'b1;
    tick     = wrap && guard_q == '0;
    state_d  = enable ? RUN : IDLE;
    cnt_d    = live && !wrap ? cnt_q + 1'b1 : '0;
    guard_d  = tick ? GUARD_LD : (guard_q == '0 ? '0 : guard_q - 1'b1);
    full_a_d = live && (ld_a || (full_a_q && !tick));
    full_b_d = live && (ld_b || (full_b_q && !tick));
    buf_a_d  = ld_a ? dataInA : buf_a_q;
    buf_b_d  = ld_b ? dataInB : buf_b_q;
    data_a_d = tick && full_a_q ? buf_a_q : data_a_q;
    data_b_d = tick && full_b_q ? buf_b_q : data_b_q;
    und_a_d  = clrUnderrun ? '0 : (tick && !full_a_q && und_a_q != 8'hFF) ? und_a_q + 8'd1 : und_a_q;
    und_b_d  = clrUnderrun ? '0 : (tick && !full_b_q && und_b_q != 8'hFF) ? und_b_q + 8'd1 : und_b_q;
    ce_d     = tick;
  end
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      eff_q    <= MINP;
      guard_q  <= '0;
      full_a_q <= 1'b0;
      full_b_q <= 1'b0;
      buf_a_q  <= '0;
      buf_b_q  <= '0;
      data_a_q <= '0;
      data_b_q <= '0;
      und_a_q  <= '0;
      und_b_q  <= '0;
      ce_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      eff_q    <= eff_d;
      guard_q  <= guard_d;
      full_a_q <= full_a_d;
      full_b_q <= full_b_d;
      buf_a_q  <= buf_a_d;
      buf_b_q  <= buf_b_d;
      data_a_q <= data_a_d;
      data_b_q <= data_b_d;
      und_a_q  <= und_a_d;
      und_b_q  <= und_b_d;
      ce_q     <= ce_d;
    end
  end
  assign ce        = ce_q;
  assign dataA     = data_a_q;
  assign dataB     = data_b_q;
  assign underrunA = und_a_q;
  assign underrunB = und_b_q;
endmodule

// File: tb/tb_dac_stream_scheduler.sv
// tb_dac_stream_scheduler: directed checks of pacing, buffering, underrun and abort behaviour.
module tb_dac_stream_scheduler;
  logic clk = 1'b0, resetN = 1'b0, enable = 1'b0, clrUnderrun = 1'b0;
  logic [15:0] period = '0;
  logic validA = 1'b0, validB = 1'b0, readyA, readyB, ce;
  logic [13:0] dataInA = '0, dataInB = '0, dataA, dataB;
  logic [7:0] underrunA, underrunB;
  int total = 0, passed = 0, failed = 0;
  dac_stream_scheduler #(.DATA_WIDTH(14), .PERIOD_WIDTH(16), .MIN_PERIOD(8)) dut (
    .clk(clk), .resetN(resetN), .enable(enable), .period(period),
    .validA(validA), .dataInA(dataInA), .readyA(readyA),
    .validB(validB), .dataInB(dataInB), .readyB(readyB),
    .ce(ce), .dataA(dataA), .dataB(dataB),
    .underrunA(underrunA), .underrunB(underrunB), .clrUnderrun(clrUnderrun));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask
  task automatic wait_ce(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ce && n < 100);
  endtask
  initial begin
    int n, bad;
    step(2);
    chk("rst_ce", ce, 0);
    chk("rst_readyA", readyA, 0);
    chk("rst_dataA", dataA, 0);
    chk("rst_underrunB", underrunB, 0);
    resetN = 1'b1;
    step(1);
    period = 16'd10; validA = 1; validB = 1; dataInA = 14'h0100; dataInB = 14'h0200; enable = 1;
    wait_ce(n);
    chk("first_ce_latency", n, 11);
    chk("first_dataA", dataA, 14'h0100);
    chk("first_dataB", dataB, 14'h0200);
    wait_ce(n);
    chk("spacing10_a", n, 10);
    step(1);
    chk("ce_one_cycle", ce, 0);
    wait_ce(n);
    chk("spacing10_b", n, 9);
    chk("no_underrunA", underrunA, 0);
    chk("no_underrunB", underrunB, 0);
    period = 16'd3;
    wait_ce(n);
    chk("clamp_p3", n, 8);
    period = 16'd0;
    wait_ce(n);
    chk("clamp_p0", n, 8);
    resetN = 0; enable = 0;
    step(1);
    resetN = 1;
    step(1);
    period = 16'd0; validA = 1; dataInA = 14'h0111; validB = 0; enable = 1;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      wait_ce(n);
      if (n != (i == 0 ? 9 : 8)) bad++;
    end
    chk("t300_spacing_errors", bad, 0);
    chk("t300_dataB_held", dataB, 0);
    chk("t300_underrunB_sat", underrunB, 255);
    chk("t300_underrunA", underrunA, 0);
    clrUnderrun = 1;
    step(1);
    clrUnderrun = 0;
    chk("clr_underrunA", underrunA, 0);
    chk("clr_underrunB", underrunB, 0);
    chk("full_not_ready", readyA, 0);
    wait_ce(n);
    chk("post_clr_spacing", n, 7);
    validA = 0;
    step(7);
    chk("tick_readyA", readyA, 1);
    validA = 1; dataInA = 14'h00AB;
    step(1);
    chk("tick_ce", ce, 1);
    chk("tick_dataA_held", dataA, 14'h0111);
    chk("tick_underrunA", underrunA, 1);
    validA = 0;
    wait_ce(n);
    chk("tick_next_spacing", n, 8);
    chk("tick_word_out", dataA, 14'h00AB);
    chk("tick_underrunA_once", underrunA, 1);
    validA = 1; period = 16'd10;
    wait_ce(n);
    chk("p10_active", n, 10);
    step(5);
    period = 16'd20;
    wait_ce(n);
    chk("p_change_current", n, 5);
    wait_ce(n);
    chk("p_change_next", n, 20);
    period = 16'd10;
    wait_ce(n);
    chk("p_back_10", n, 10);
    dataInA = 14'h03FF; validB = 1; dataInB = 14'h02AA;
    step(7);
    enable = 0; validA = 0; validB = 0; clrUnderrun = 1;
    step(1);
    chk("abort_readyA", readyA, 0);
    chk("abort_readyB", readyB, 0);
    chk("abort_ce", ce, 0);
    chk("abort_clr", underrunA, 0);
    enable = 1; clrUnderrun = 0;
    wait_ce(n);
    chk("reenter_latency", n, 11);
    chk("reenter_dataA", dataA, 14'h00AB);
    chk("reenter_dataB", dataB, 0);
    chk("flush_underrunA", underrunA, 1);
    chk("flush_underrunB", underrunB, 1);
    step(3);
    resetN = 0; enable = 0;
    #1;
    chk("async_rst_readyA", readyA, 0);
    chk("async_rst_dataA", dataA, 0);
    chk("async_rst_underrunA", underrunA, 0);
    step(1);
    chk("async_rst_ce", ce, 0);
    resetN = 1;
    step(3);
    chk("idle_after_rst", readyA, 0);
    enable = 1;
    wait_ce(n);
    chk("rst_restart_latency", n, 11);
    chk("rst_restart_dataA", dataA, 0);
    chk("rst_restart_underrunA", underrunA, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
